welford_mult_sched: RTL

//  Round-robin scheduler sharing one signed multiplier (multiply, W x W -> 2W+1) among
//  N_REQ requesters inside the welford extern (mean/variance update terms).

---
 rtl/welford_mult_sched_pkg.sv | 15 +
 rtl/welford_mult_sched_multiply.sv | 21 ++
 rtl/welford_mult_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/welford_mult_sched_pkg.sv
// Shared defaults for the welford extern multiplier scheduler.
// Also provides the width of the sign-extended product.
package welford_mult_sched_pkg;

    localparam int DEF_MULT_WORD_SMALL_SIZE = 18;
    localparam int DEF_N_REQ                = 4;
    localparam int DEF_ID_WIDTH             = 2;
    localparam int DEF_PIPE_STAGES          = 2;

    // One guard bit above 2W keeps the shared product port common across welford blocks.
    function automatic int prod_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/welford_mult_sched_multiply.sv
// Combinational signed W x W multiplier. OUTPUT_WIDTH must be at least 2W so the
// product is exact, including the most-negative by most-negative case.
module welford_mult_sched_multiply
    import welford_mult_sched_pkg::*;
#(
    parameter int W            = DEF_MULT_WORD_SMALL_SIZE,
    parameter int OUTPUT_WIDTH = 2 * DEF_MULT_WORD_SMALL_SIZE
) (
    input  logic signed [W-1:0]            a,
    input  logic signed [W-1:0]            b,
    output logic signed [OUTPUT_WIDTH-1:0] p
);

    logic signed [OUTPUT_WIDTH-1:0] a_ext;
    logic signed [OUTPUT_WIDTH-1:0] b_ext;

    assign a_ext = OUTPUT_WIDTH'(a);
    assign b_ext = OUTPUT_WIDTH'(b);
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/welford_mult_sched.sv
// Round-robin scheduler sharing one signed multiplier among N_REQ requesters.
// One grant per cycle; products return in grant order, tagged with the requester index.
module welford_mult_sched
    import welford_mult_sched_pkg::*;
#(
    parameter int MULT_WORD_SMALL_SIZE = DEF_MULT_WORD_SMALL_SIZE,
    parameter int N_REQ                = DEF_N_REQ,
    parameter int ID_WIDTH             = DEF_ID_WIDTH,
    parameter int PIPE_STAGES          = DEF_PIPE_STAGES
) (
    input  logic                                     clk_lookup,
    input  logic                                     rst,
    input  logic                                     enable,
    input  logic [N_REQ-1:0]                         req_valid,
    input  logic [N_REQ*MULT_WORD_SMALL_SIZE-1:0]    req_x,
    input  logic [N_REQ*MULT_WORD_SMALL_SIZE-1:0]    req_y,
    output logic [N_REQ-1:0]                         req_ready,
    output logic                                     res_valid,
    output logic [ID_WIDTH-1:0]                      res_id,
    output logic signed [prod_width(MULT_WORD_SMALL_SIZE)-1:0] res_data,
    output logic                                     busy
);

    localparam int W  = MULT_WORD_SMALL_SIZE;
    localparam int MW = 2 * W;
    localparam int PW = prod_width(W);

    function automatic logic signed [PW-1:0] sext_prod(input logic signed [MW-1:0] p);
        return {p[MW-1], p};
    endfunction

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic                  gnt_vld;
    logic [ID_WIDTH-1:0]   gnt_id;
    int                    idx;

    logic                  vld_p0;
    logic [ID_WIDTH-1:0]   id_p0;
    logic signed [W-1:0]   x_p0;
    logic signed [W-1:0]   y_p0;
    logic signed [MW-1:0]  prod_p0;

    logic                  vld_p  [1:PIPE_STAGES];
    logic [ID_WIDTH-1:0]   id_p   [1:PIPE_STAGES];
    logic signed [PW-1:0]  prod_p [1:PIPE_STAGES];

    // Priority search starting at rr_ptr and wrapping, i.e. over the rotated valid vector.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        if (enable) begin
            for (int j = 0; j < N_REQ; j++) begin
                idx = int'(rr_ptr) + j;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!gnt_vld && req_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ID_WIDTH'(idx);
                end
            end
        end
    end

    assign req_ready = gnt_vld ? (N_REQ'(1) << gnt_id) : '0;

    // Stage 0: operand capture on grant
    always_ff @(posedge clk_lookup) begin
        if (gnt_vld) begin
            x_p0  <= req_x[gnt_id*W +: W];
            y_p0  <= req_y[gnt_id*W +: W];
            id_p0 <= gnt_id;
        end
    end

    welford_mult_sched_multiply #(
        .W            (W),
        .OUTPUT_WIDTH (MW)
    ) u_multiply (
        .a (x_p0),
        .b (y_p0),
        .p (prod_p0)
    );

    // Stages 1..PIPE_STAGES: product pipeline; data moves only alongside a valid op
    always_ff @(posedge clk_lookup or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            vld_p0 <= 1'b0;
            for (int s = 1; s <= PIPE_STAGES; s++) begin
                vld_p[s]  <= 1'b0;
                id_p[s]   <= '0;
                prod_p[s] <= '0;
            end
        end else begin
            if (gnt_vld)
                rr_ptr <= (gnt_id == ID_WIDTH'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
            vld_p0   <= gnt_vld;
            vld_p[1] <= vld_p0;
            if (vld_p0) begin
                id_p[1]   <= id_p0;
                prod_p[1] <= sext_prod(prod_p0);
            end
            for (int s = 2; s <= PIPE_STAGES; s++) begin
                vld_p[s] <= vld_p[s-1];
                if (vld_p[s-1]) begin
                    id_p[s]   <= id_p[s-1];
                    prod_p[s] <= prod_p[s-1];
                end
            end
        end
    end

    assign res_valid = vld_p[PIPE_STAGES];
    assign res_id    = id_p[PIPE_STAGES];
    assign res_data  = prod_p[PIPE_STAGES];

    always_comb begin
        busy = vld_p0;
        for (int s = 1; s <= PIPE_STAGES; s++)
            busy = busy | vld_p[s];
    end

endmodule
